dbus_lsu_initiator: RTL and testbench
=====================================

# dbus_lsu_initiator

Initiator end of the core data bus (dbus). Accepts one load/store at a time from the LSU pipeline stage and issues a word-aligned dbus request with lane-aligned write data and byte strobes. For loads, it waits for the read response, then extracts, aligns and sign- or zero-extends the requested lanes. It returns one completion per operation to the pipeline and sits between the LSU stage and any dbus responder: memory model, synthesis bridge or SoC crossbar.

## Interface
Parameters: none; the data and address widths are fixed at 32.

- `clock`  in  1  sole clock; all state changes on its rising edge
- `reset`  in  1  asynchronous, active-low reset
- `io_lsu_req_valid`  in  1  operation offered by the pipeline
- `io_lsu_req_ready`  out  1  block can accept an operation (1 iff state IDLE)
- `io_lsu_req_bits_addr`  in  32  byte address
- `io_lsu_req_bits_wdata`  in  32  store data in the low bits
- `io_lsu_req_bits_wen`  in  1  1 = store, 0 = load
- `io_lsu_req_bits_size`  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word
- `io_lsu_req_bits_unsigned`  in  1  load zero-extends when 1, sign-extends when 0
- `io_lsu_resp_valid`  out  1  completion available
- `io_lsu_resp_ready`  in  1  pipeline accepts the completion
- `io_lsu_resp_bits_rdata`  out  32  extended load data; 0 for stores
- `io_lsu_resp_bits_err`  out  1  misaligned access (see Configuration)
- `io_bus_req_valid`  out  1  dbus request valid
- `io_bus_req_ready`  in  1  responder accepts the request
- `io_bus_req_bits_addr`  out  32  {addr[31:2], 2'b00}
- `io_bus_req_bits_wdata`  out  32  lane-replicated store data
- `io_bus_req_bits_wen`  out  1  store flag
- `io_bus_req_bits_wstrb`  out  4  byte enables; 0 for loads
- `io_bus_resp_valid`  in  1  read data valid (loads only)
- `io_bus_resp_ready`  out  1  block accepts read data
- `io_bus_resp_bits`  in  32  raw read word

## Operation
**Request capture**
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- When `io_lsu_req_valid` and ready are both high in IDLE, the block registers addr, wdata, wen, size and unsigned, then moves to REQ.

**REQ state**
- `io_bus_req_valid` = 1 and the bus request fields are driven from the registered operation.
- On `io_bus_req_ready`, a store goes to DONE.
- On `io_bus_req_ready`, a load goes to WAIT, or straight to DONE if `io_bus_resp_valid` is also high in that same cycle.

**Bus response acceptance**
- `io_bus_resp_ready` = (WAIT) | (REQ & ~wen & `io_bus_req_ready`).
- A response is therefore never accepted before its request has been accepted.
- A `io_bus_resp_valid` seen while in IDLE, DONE, or REQ without the request handshake is ignored.

**WAIT state**
- On `io_bus_resp_valid` the raw word is captured and the state moves to DONE.
- There is no timeout.

**DONE state**
- `io_lsu_resp_valid` = 1 and all response fields are held stable.
- On `io_lsu_resp_ready` the state returns to IDLE.
- A new `io_lsu_req` can be accepted in the cycle after that return to IDLE.

**Store lane generation**
- Strobes:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1], 1'b0}
  - word: 4'b1111
- wdata:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata

**Load extraction**
- The raw word is shifted right by {addr[1:0], 3'b000} (word ignores addr[1:0]).
- Bits 7:0 or 15:0 are then extended per `unsigned`; word loads pass through unchanged.
- Extraction is performed on the registered raw word, so rdata is stable throughout DONE.

## Timing
- Reset values: state IDLE, so `io_lsu_req_ready` = 1. Every other output is 0: `io_bus_req_valid`, `io_bus_resp_ready`, `io_lsu_resp_valid`, rdata, err and all bus fields.
- Reset asserted mid-operation immediately returns the FSM to IDLE and drops `io_bus_req_valid`. Any pending response is abandoned and the responder remains stalled because resp_ready stays 0.
- Load with a zero-wait responder: operation accepted at cycle 0, REQ and response at cycle 1, `io_lsu_resp_valid` at cycle 2.
- Store: `io_lsu_resp_valid` one cycle after the bus request handshake.
- Backpressure: `io_bus_req_valid` holds with stable fields until ready. `io_lsu_resp_valid` holds until ready.
- At most one operation is outstanding.

## Configuration
Macro: `DBUS_MISALIGN_TRAP_EN`.

- **Defined:** a half access with addr[0]=1, or a word access with addr[1:0]≠0, skips REQ and goes IDLE→DONE with err=1 and rdata=0. No bus request is issued.
- **Undefined:** err is tied to 0 and misaligned accesses proceed. A half access uses addr[1] only; a word access ignores addr[1:0].

## Test plan
- Load word at 0x1000 with a zero-wait responder returning 0xDEADBEEF → bus addr 0x1000, wstrb 0, `io_lsu_resp_valid` at cycle 2, rdata 0xDEADBEEF.
- Signed byte load at 0x1003, response 0x80FFFFFF → rdata 0xFFFFFF80. The same load with unsigned=1 → 0x00000080.
- Half store of 0x1234ABCD at 0x2002 → one bus request with addr 0x2000, wstrb 4'b1100, wdata 0xABCDABCD. Completion has rdata 0 and no bus response is consumed.
- Load with req_ready low for 3 cycles and the response 5 cycles after acceptance → request fields stable throughout, resp_ready only in WAIT, completion with correct data; `io_lsu_resp_ready` held low 4 cycles → rdata stable.
- Misaligned word load at 0x3001 → with the macro, err=1, no `io_bus_req_valid`, completion at cycle 1. Without the macro, bus addr is 0x3000 and err=0.
- Reset pulsed low while in WAIT → `io_bus_req_valid`, `io_bus_resp_ready` and `io_lsu_resp_valid` go to 0 asynchronously and `io_lsu_req_ready` goes to 1. A late `io_bus_resp_valid` produces no completion.

Source files
------------

// File: rtl/dbus_lsu_initiator_if.sv
// Signal bundle between the LSU pipeline stage, the initiator and a dbus responder.
// The master modport is the initiator's view; slave is the opposite side.
interface dbus_lsu_initiator_if;
    logic        io_lsu_req_valid;
    logic        io_lsu_req_ready;
    logic [31:0] io_lsu_req_bits_addr;
    logic [31:0] io_lsu_req_bits_wdata;
    logic        io_lsu_req_bits_wen;
    logic [1:0]  io_lsu_req_bits_size;
    logic        io_lsu_req_bits_unsigned;
    logic        io_lsu_resp_valid;
    logic        io_lsu_resp_ready;
    logic [31:0] io_lsu_resp_bits_rdata;
    logic        io_lsu_resp_bits_err;
    logic        io_bus_req_valid;
    logic        io_bus_req_ready;
    logic [31:0] io_bus_req_bits_addr;
    logic [31:0] io_bus_req_bits_wdata;
    logic        io_bus_req_bits_wen;
    logic [3:0]  io_bus_req_bits_wstrb;
    logic        io_bus_resp_valid;
    logic        io_bus_resp_ready;
    logic [31:0] io_bus_resp_bits;

    modport master (
        input  io_lsu_req_valid, io_lsu_req_bits_addr, io_lsu_req_bits_wdata,
               io_lsu_req_bits_wen, io_lsu_req_bits_size, io_lsu_req_bits_unsigned,
               io_lsu_resp_ready, io_bus_req_ready, io_bus_resp_valid, io_bus_resp_bits,
        output io_lsu_req_ready, io_lsu_resp_valid, io_lsu_resp_bits_rdata,
               io_lsu_resp_bits_err, io_bus_req_valid, io_bus_req_bits_addr,
               io_bus_req_bits_wdata, io_bus_req_bits_wen, io_bus_req_bits_wstrb,
               io_bus_resp_ready
    );

    modport slave (
        output io_lsu_req_valid, io_lsu_req_bits_addr, io_lsu_req_bits_wdata,
               io_lsu_req_bits_wen, io_lsu_req_bits_size, io_lsu_req_bits_unsigned,
               io_lsu_resp_ready, io_bus_req_ready, io_bus_resp_valid, io_bus_resp_bits,
        input  io_lsu_req_ready, io_lsu_resp_valid, io_lsu_resp_bits_rdata,
               io_lsu_resp_bits_err, io_bus_req_valid, io_bus_req_bits_addr,
               io_bus_req_bits_wdata, io_bus_req_bits_wen, io_bus_req_bits_wstrb,
               io_bus_resp_ready
    );
endinterface

// File: rtl/dbus_lsu_initiator.sv
// dbus initiator: one LSU load/store at a time, lane-aligned stores, extended loads.
// Optional DBUS_MISALIGN_TRAP_EN: misaligned half/word accesses complete with err=1 and no bus request.
module dbus_lsu_initiator (
    input  logic                 clock,
    input  logic                 reset,
    dbus_lsu_initiator_if.master io
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state_reg, state_next;
    logic [31:0] addr_reg, wdata_reg, raw_reg;
    logic        wen_reg, unsigned_reg;
    logic [1:0]  size_reg;

    logic        lsu_req_ready, lsu_resp_valid, bus_req_valid, bus_resp_ready;
    logic        accept, resp_fire, err_flag;
    logic [31:0] bus_wdata, shifted, extended;
    logic [3:0]  bus_wstrb;
    logic [4:0]  shamt;

    assign accept    = (state_reg == IDLE) & io.io_lsu_req_valid;
    assign resp_fire = bus_resp_ready & io.io_bus_resp_valid;

`ifdef DBUS_MISALIGN_TRAP_EN
    logic err_reg, misaligned;
    assign misaligned = ((io.io_lsu_req_bits_size == 2'd1) & io.io_lsu_req_bits_addr[0]) |
                        (io.io_lsu_req_bits_size[1] & (|io.io_lsu_req_bits_addr[1:0]));
    assign err_flag   = err_reg;
`else
    assign err_flag   = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            raw_reg      <= '0;
            wen_reg      <= 1'b0;
            unsigned_reg <= 1'b0;
            size_reg     <= 2'd0;
`ifdef DBUS_MISALIGN_TRAP_EN
            err_reg      <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            if (accept) begin
                addr_reg     <= io.io_lsu_req_bits_addr;
                wdata_reg    <= io.io_lsu_req_bits_wdata;
                wen_reg      <= io.io_lsu_req_bits_wen;
                size_reg     <= io.io_lsu_req_bits_size;
                unsigned_reg <= io.io_lsu_req_bits_unsigned;
`ifdef DBUS_MISALIGN_TRAP_EN
                err_reg      <= misaligned;
`endif
            end
            if (resp_fire)
                raw_reg <= io.io_bus_resp_bits;
        end
    end

    always_comb begin
        state_next     = state_reg;
        lsu_req_ready  = 1'b0;
        lsu_resp_valid = 1'b0;
        bus_req_valid  = 1'b0;
        bus_resp_ready = 1'b0;
        case (state_reg)
            IDLE: begin
                lsu_req_ready = 1'b1;
                if (io.io_lsu_req_valid) begin
`ifdef DBUS_MISALIGN_TRAP_EN
                    state_next = misaligned ? DONE : REQ;
`else
                    state_next = REQ;
`endif
                end
            end
            REQ: begin
                bus_req_valid = 1'b1;
                if (io.io_bus_req_ready) begin
                    if (wen_reg) begin
                        state_next = DONE;
                    end else begin
                        // A zero-wait responder may answer in the same cycle it takes the request.
                        bus_resp_ready = 1'b1;
                        state_next     = io.io_bus_resp_valid ? DONE : WAIT;
                    end
                end
            end
            WAIT: begin
                bus_resp_ready = 1'b1;
                if (io.io_bus_resp_valid)
                    state_next = DONE;
            end
            DONE: begin
                lsu_resp_valid = 1'b1;
                if (io.io_lsu_resp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Per-lane store data and strobe: bytes replicate to all lanes, halves to both half-words.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        logic lane_hit;
        always_comb begin
            lane_hit = 1'b1;
            bus_wdata[8*gi +: 8] = wdata_reg[8*gi +: 8];
            case (size_reg)
                2'd0: begin
                    lane_hit             = (addr_reg[1:0] == LANE);
                    bus_wdata[8*gi +: 8] = wdata_reg[7:0];
                end
                2'd1: begin
                    lane_hit             = (addr_reg[1] == LANE[1]);
                    bus_wdata[8*gi +: 8] = wdata_reg[8*LANE[0] +: 8];
                end
                default: ;
            endcase
        end
        assign bus_wstrb[gi] = wen_reg & lane_hit;
    end

    always_comb begin
        shamt = 5'd0;
        case (size_reg)
            2'd0:    shamt = {addr_reg[1:0], 3'b000};
            2'd1:    shamt = {addr_reg[1], 4'b0000};
            default: shamt = 5'd0;
        endcase
        shifted  = raw_reg >> shamt;
        extended = raw_reg;
        case (size_reg)
            2'd0:    extended = {{24{~unsigned_reg & shifted[7]}}, shifted[7:0]};
            2'd1:    extended = {{16{~unsigned_reg & shifted[15]}}, shifted[15:0]};
            default: extended = raw_reg;
        endcase
    end

    assign io.io_lsu_req_ready       = lsu_req_ready;
    assign io.io_lsu_resp_valid      = lsu_resp_valid;
    assign io.io_lsu_resp_bits_rdata = (wen_reg | err_flag) ? 32'd0 : extended;
    assign io.io_lsu_resp_bits_err   = err_flag;
    assign io.io_bus_req_valid       = bus_req_valid;
    assign io.io_bus_req_bits_addr   = {addr_reg[31:2], 2'b00};
    assign io.io_bus_req_bits_wdata  = bus_wdata;
    assign io.io_bus_req_bits_wen    = wen_reg;
    assign io.io_bus_req_bits_wstrb  = bus_wstrb;
    assign io.io_bus_resp_ready      = bus_resp_ready;
endmodule

// File: tb/tb_dbus_lsu_initiator.sv
// Bench for dbus_lsu_initiator: directed cases with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model. Honours DBUS_MISALIGN_TRAP_EN.
module tb_dbus_lsu_initiator;
    logic clock;
    logic reset;
    dbus_lsu_initiator_if bus ();

    dbus_lsu_initiator dut (.clock(clock), .reset(reset), .io(bus));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_mis = 0;
    int n_done = 0;

    // transaction-level model state
    logic        m_busy = 1'b0, m_req_done = 1'b0, m_resp_done = 1'b0, m_trap = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_raw = '0;
    logic        m_wen = 1'b0, m_uns = 1'b0;
    logic [1:0]  m_size = '0;

    // observations from the directed driver
    logic        obs_saw, obs_err;
    int          obs_lat;
    logic [31:0] obs_rdata, obs_baddr, obs_bwdata;
    logic [3:0]  obs_wstrb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_cmp++;
        n_mis++;
        $display("FAIL %s: got timeout expected handshake at %0t", nm, $time);
    endtask

    function automatic logic f_trap(input logic [31:0] a, input logic [1:0] s);
`ifdef DBUS_MISALIGN_TRAP_EN
        if (s == 2'd1) return (a % 2) != 0;
        if (s >= 2'd2) return (a % 4) != 0;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] f_wstrb(input logic [31:0] a, input logic [1:0] s, input logic w);
        if (!w) return 4'd0;
        if (s == 2'd0) return 4'(1 << (a % 4));
        if (s == 2'd1) return ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] f_wdata(input logic [31:0] d, input logic [1:0] s);
        if (s == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (s == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] f_rdata(input logic [31:0] raw, input logic [31:0] a,
                                            input logic [1:0] s, input logic u);
        logic [31:0] v;
        if (s == 2'd0) begin
            v = (raw >> (8 * (a % 4))) & 32'hFF;
            if (!u && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (s == 2'd1) begin
            v = (raw >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (!u && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = raw;
        end
        return v;
    endfunction

    // Single compare process: checks outputs against the model, then advances the model.
    always begin
        logic e_rdy, e_breq, e_lresp, e_bresp;
        @(negedge clock);
        #2;
        if (!reset) begin
            chk("rst_lsu_req_ready", bus.io_lsu_req_ready, 1);
            chk("rst_bus_req_valid", bus.io_bus_req_valid, 0);
            chk("rst_bus_resp_ready", bus.io_bus_resp_ready, 0);
            chk("rst_lsu_resp_valid", bus.io_lsu_resp_valid, 0);
            chk("rst_rdata", bus.io_lsu_resp_bits_rdata, 0);
            chk("rst_err", bus.io_lsu_resp_bits_err, 0);
            chk("rst_bus_addr", bus.io_bus_req_bits_addr, 0);
            chk("rst_bus_wdata", bus.io_bus_req_bits_wdata, 0);
            chk("rst_bus_wen", bus.io_bus_req_bits_wen, 0);
            chk("rst_bus_wstrb", bus.io_bus_req_bits_wstrb, 0);
            m_busy = 1'b0;
        end else begin
            e_rdy   = !m_busy;
            e_breq  = m_busy && !m_trap && !m_req_done;
            e_lresp = m_busy && (m_trap || (m_wen ? m_req_done : m_resp_done));
            e_bresp = m_busy && !m_trap && !m_wen && !m_resp_done &&
                      (m_req_done || bus.io_bus_req_ready);
            chk("lsu_req_ready", bus.io_lsu_req_ready, e_rdy);
            chk("bus_req_valid", bus.io_bus_req_valid, e_breq);
            chk("lsu_resp_valid", bus.io_lsu_resp_valid, e_lresp);
            chk("bus_resp_ready", bus.io_bus_resp_ready, e_bresp);
            if (e_breq) begin
                chk("bus_addr", bus.io_bus_req_bits_addr, m_addr - (m_addr % 4));
                chk("bus_wdata", bus.io_bus_req_bits_wdata, f_wdata(m_wdata, m_size));
                chk("bus_wen", bus.io_bus_req_bits_wen, m_wen);
                chk("bus_wstrb", bus.io_bus_req_bits_wstrb, f_wstrb(m_addr, m_size, m_wen));
            end
            if (e_lresp) begin
                chk("lsu_rdata", bus.io_lsu_resp_bits_rdata,
                    (m_wen || m_trap) ? 32'd0 : f_rdata(m_raw, m_addr, m_size, m_uns));
                chk("lsu_err", bus.io_lsu_resp_bits_err, m_trap);
            end
            if (!m_busy) begin
                if (bus.io_lsu_req_valid) begin
                    m_busy      = 1'b1;
                    m_req_done  = 1'b0;
                    m_resp_done = 1'b0;
                    m_addr      = bus.io_lsu_req_bits_addr;
                    m_wdata     = bus.io_lsu_req_bits_wdata;
                    m_wen       = bus.io_lsu_req_bits_wen;
                    m_size      = bus.io_lsu_req_bits_size;
                    m_uns       = bus.io_lsu_req_bits_unsigned;
                    m_trap      = f_trap(m_addr, m_size);
                end
            end else if (e_lresp && bus.io_lsu_resp_ready) begin
                m_busy = 1'b0;
                n_done++;
            end else begin
                if (e_breq && bus.io_bus_req_ready) m_req_done = 1'b1;
                if (e_bresp && bus.io_bus_resp_valid) begin
                    m_resp_done = 1'b1;
                    m_raw       = bus.io_bus_resp_bits;
                end
            end
        end
    end

    task automatic drive_idle();
        bus.io_lsu_req_valid  = 1'b0;
        bus.io_lsu_resp_ready = 1'b0;
        bus.io_bus_req_ready  = 1'b0;
        bus.io_bus_resp_valid = 1'b0;
        bus.io_bus_resp_bits  = 32'd0;
    endtask

    // Directed operation: cycle 0 is acceptance; bus ready rises after req_stall cycles,
    // response valid from cycle rsp_delay, completion accepted lr_stall cycles after it appears.
    task automatic run_op(input logic [31:0] a, input logic [31:0] wd, input logic w,
                          input logic [1:0] sz, input logic u, input int req_stall,
                          input int rsp_delay, input int lr_stall, input logic [31:0] word);
        int c, t, first;
        bit done;
        obs_saw = 1'b0; obs_err = 1'b0; obs_lat = -1;
        obs_rdata = '0; obs_baddr = '0; obs_bwdata = '0; obs_wstrb = '0;
        @(negedge clock);
        drive_idle();
        bus.io_lsu_req_valid         = 1'b1;
        bus.io_lsu_req_bits_addr     = a;
        bus.io_lsu_req_bits_wdata    = wd;
        bus.io_lsu_req_bits_wen      = w;
        bus.io_lsu_req_bits_size     = sz;
        bus.io_lsu_req_bits_unsigned = u;
        #1;
        t = 0;
        while (!bus.io_lsu_req_ready && t < 20) begin
            @(negedge clock);
            #1;
            t++;
        end
        if (t == 20) begin
            timeout_fail("op_accept");
            return;
        end
        c = 0; first = -1; done = 0;
        while (!done && c < 60) begin
            @(negedge clock);
            c++;
            bus.io_lsu_req_valid  = 1'b0;
            bus.io_bus_req_ready  = (c > req_stall);
            bus.io_bus_resp_valid = (c >= rsp_delay);
            bus.io_bus_resp_bits  = word;
            #1;
            if (bus.io_bus_req_valid && bus.io_bus_req_ready && !obs_saw) begin
                obs_saw    = 1'b1;
                obs_baddr  = bus.io_bus_req_bits_addr;
                obs_bwdata = bus.io_bus_req_bits_wdata;
                obs_wstrb  = bus.io_bus_req_bits_wstrb;
            end
            if (bus.io_lsu_resp_valid && first < 0) begin
                first     = c;
                obs_lat   = c;
                obs_rdata = bus.io_lsu_resp_bits_rdata;
                obs_err   = bus.io_lsu_resp_bits_err;
            end
            bus.io_lsu_resp_ready = (first >= 0) && (c >= first + lr_stall);
            done = bus.io_lsu_resp_valid && bus.io_lsu_resp_ready;
        end
        if (!done) timeout_fail("op_complete");
    endtask

    initial begin
        reset = 1'b0;
        drive_idle();
        bus.io_lsu_req_bits_addr     = '0;
        bus.io_lsu_req_bits_wdata    = '0;
        bus.io_lsu_req_bits_wen      = 1'b0;
        bus.io_lsu_req_bits_size     = 2'd0;
        bus.io_lsu_req_bits_unsigned = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;

        run_op(32'h1000, 32'h0, 1'b0, 2'd2, 1'b0, 0, 1, 0, 32'hDEAD_BEEF);
        $display("op load word 0x1000: lat=%0d rdata=%08h addr=%08h", obs_lat, obs_rdata, obs_baddr);
        chk("lw_latency", obs_lat, 2);
        chk("lw_rdata", obs_rdata, 32'hDEAD_BEEF);
        chk("lw_bus_addr", obs_baddr, 32'h1000);
        chk("lw_wstrb", obs_wstrb, 0);

        run_op(32'h1003, 32'h0, 1'b0, 2'd0, 1'b0, 0, 1, 0, 32'h80FF_FFFF);
        $display("op load signed byte 0x1003: rdata=%08h", obs_rdata);
        chk("lb_rdata", obs_rdata, 32'hFFFF_FF80);
        run_op(32'h1003, 32'h0, 1'b0, 2'd0, 1'b1, 0, 1, 0, 32'h80FF_FFFF);
        $display("op load unsigned byte 0x1003: rdata=%08h", obs_rdata);
        chk("lbu_rdata", obs_rdata, 32'h0000_0080);

        run_op(32'h2002, 32'h1234_ABCD, 1'b1, 2'd1, 1'b0, 0, 1, 0, 32'hFFFF_0000);
        $display("op store half 0x2002: addr=%08h wstrb=%h wdata=%08h lat=%0d",
                 obs_baddr, obs_wstrb, obs_bwdata, obs_lat);
        chk("sh_bus_addr", obs_baddr, 32'h2000);
        chk("sh_wstrb", obs_wstrb, 4'b1100);
        chk("sh_wdata", obs_bwdata, 32'hABCD_ABCD);
        chk("sh_rdata", obs_rdata, 0);
        chk("sh_latency", obs_lat, 2);

        run_op(32'h42, 32'h0, 1'b0, 2'd1, 1'b1, 3, 5, 4, 32'h8001_1234);
        $display("op load half stalled 0x42: lat=%0d rdata=%08h", obs_lat, obs_rdata);
        chk("lhu_stall_latency", obs_lat, 6);
        chk("lhu_stall_rdata", obs_rdata, 32'h0000_8001);
        chk("lhu_stall_addr", obs_baddr, 32'h40);

        run_op(32'h3001, 32'h0, 1'b0, 2'd2, 1'b0, 0, 1, 0, 32'h1122_3344);
        $display("op misaligned word 0x3001: saw_req=%0d err=%0d lat=%0d rdata=%08h",
                 obs_saw, obs_err, obs_lat, obs_rdata);
`ifdef DBUS_MISALIGN_TRAP_EN
        chk("mis_err", obs_err, 1);
        chk("mis_no_bus_req", obs_saw, 0);
        chk("mis_latency", obs_lat, 1);
        chk("mis_rdata", obs_rdata, 0);
`else
        chk("mis_err", obs_err, 0);
        chk("mis_bus_addr", obs_baddr, 32'h3000);
        chk("mis_rdata", obs_rdata, 32'h1122_3344);
`endif

        // reset pulse while waiting for a read response
        @(negedge clock);
        drive_idle();
        bus.io_lsu_req_valid     = 1'b1;
        bus.io_lsu_req_bits_addr = 32'h50;
        bus.io_lsu_req_bits_wen  = 1'b0;
        bus.io_lsu_req_bits_size = 2'd2;
        bus.io_bus_req_ready     = 1'b1;
        @(negedge clock);
        bus.io_lsu_req_valid = 1'b0;
        @(negedge clock);
        #1;
        chk("wait_resp_ready", bus.io_bus_resp_ready, 1);
        #2;
        reset = 1'b0;
        #1;
        $display("op reset in WAIT: req_valid=%0d resp_ready=%0d lsu_resp_valid=%0d req_ready=%0d",
                 bus.io_bus_req_valid, bus.io_bus_resp_ready, bus.io_lsu_resp_valid, bus.io_lsu_req_ready);
        chk("arst_bus_req_valid", bus.io_bus_req_valid, 0);
        chk("arst_bus_resp_ready", bus.io_bus_resp_ready, 0);
        chk("arst_lsu_resp_valid", bus.io_lsu_resp_valid, 0);
        chk("arst_lsu_req_ready", bus.io_lsu_req_ready, 1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        bus.io_bus_req_ready  = 1'b0;
        bus.io_bus_resp_valid = 1'b1;
        bus.io_bus_resp_bits  = 32'h5555_AAAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            chk("late_resp_no_completion", bus.io_lsu_resp_valid, 0);
        end
        @(negedge clock);
        drive_idle();

        // randomized traffic; the compare process checks every cycle
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            bus.io_lsu_req_valid         = ($urandom_range(0, 2) != 0);
            bus.io_lsu_req_bits_addr     = $urandom;
            bus.io_lsu_req_bits_wdata    = $urandom;
            bus.io_lsu_req_bits_wen      = $urandom_range(0, 1);
            bus.io_lsu_req_bits_size     = 2'($urandom_range(0, 3));
            bus.io_lsu_req_bits_unsigned = $urandom_range(0, 1);
            bus.io_lsu_resp_ready        = $urandom_range(0, 1);
            bus.io_bus_req_ready         = ($urandom_range(0, 3) != 0);
            bus.io_bus_resp_valid        = ($urandom_range(0, 2) == 0);
            bus.io_bus_resp_bits         = $urandom;
        end
        @(negedge clock);
        drive_idle();
        repeat (2) @(negedge clock);
        $display("random phase: %0d completions", n_done);
        chk("rand_completions_seen", (n_done > 100) ? 32'd1 : 32'd0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
